// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard detection unit and its benches.
package hazard_pkg;

    // Register-index width. The slot struct below is sized from this value.
    localparam int REG_W_DEF = 5;

    // Operand source select encoding used by fwd_sel_a/fwd_sel_b.
    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_NONE = 2'b00;
    localparam fwd_sel_t FWD_EX   = 2'b01;
    localparam fwd_sel_t FWD_MEM  = 2'b10;

    // Descriptor carried by each in-flight pipeline slot (EX, MEM, WB).
    typedef struct packed {
        logic                 valid;
        logic [REG_W_DEF-1:0] rd;
        logic                 is_load;
        logic                 is_store;
        logic                 is_branch;
        logic                 pred_taken;
    } slot_t;

    // Downstream resolver state encoding; kept here so benches can decode it.
    typedef enum logic [2:0] {
        NOR  = 3'd0,
        DAT  = 3'd1,
        FWD  = 3'd2,
        STR  = 3'd3,
        CTL  = 3'd4,
        BRN  = 3'd5,
        STAN = 3'd6
    } resolver_state_t;

    // A source hits a slot when it names a real register that the slot writes.
    function automatic logic src_match(input logic [REG_W_DEF-1:0] src,
                                       input slot_t                s);
        return (src != '0) && s.valid && (s.rd == src);
    endfunction

endpackage

// File: rtl/hdu_slot_pipe.sv
// EX/MEM/WB shadow shift register with flush and freeze handling.
module hdu_slot_pipe
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  freeze_i,
    input  logic  flush_i,
    input  slot_t id_slot_i,
    output slot_t ex_o,
    output slot_t mem_o,
    output slot_t wb_o,
    output logic  mem_enter_o
);

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;
    slot_t wb_q, wb_d;

    // Next-slot selection: flush drops ID and squashes EX, freeze bubbles EX.
    always_comb begin
        ex_d  = id_slot_i;
        mem_d = ex_q;
        wb_d  = mem_q;
        if (flush_i) begin
            ex_d        = ex_q;
            ex_d.valid  = 1'b0;
            mem_d.valid = 1'b0;
        end else if (freeze_i) begin
            ex_d       = ex_q;
            ex_d.valid = 1'b0;
        end
    end

    // Slot registers; reset leaves every slot invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_o        = ex_q;
    assign mem_o       = mem_q;
    assign wb_o        = wb_q;
    assign mem_enter_o = mem_d.valid && (mem_d.is_load || mem_d.is_store);

endmodule

// File: rtl/hazard_detect_unit.sv
// Hazard detection: compares the ID instruction against in-flight slots and
// registers the resolver condition flags and forwarding selects.
// REG_W must match hazard_pkg::REG_W_DEF, which sizes the slot descriptors.
module hazard_detect_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int MEM_BUSY_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_is_load,
    input  logic             id_is_store,
    input  logic             id_is_branch,
    input  logic             id_pred_taken,
    input  logic             ex_br_resolve,
    input  logic             ex_br_taken,
    input  logic             pc_freeze,
    input  logic             do_flush,
    output logic             data,
    output logic             fwrd,
    output logic             str,
    output logic             ctrl,
    output logic             branch,
    output logic             crct,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b
);

    localparam logic [2:0] BUSY_RELOAD = 3'(MEM_BUSY_CYC - 1);

    slot_t id_slot;
    slot_t ex_slot, mem_slot, wb_slot;
    logic  mem_enter;

    logic [2:0] mem_busy_q, mem_busy_d;

    logic rs1_ex, rs1_mem, rs2_ex, rs2_mem;
    logic data_d, fwrd_d, str_d, ctrl_d, branch_d, crct_d;
    fwd_sel_t sel_a_d, sel_b_d;

    logic data_q, fwrd_q, str_q, ctrl_q, branch_q, crct_q;
    fwd_sel_t sel_a_q, sel_b_q;

    // WB and a few descriptor fields are only observed, never compared.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{wb_slot, ex_slot.is_store, mem_slot.is_load,
                                mem_slot.is_store, mem_slot.is_branch,
                                mem_slot.pred_taken};

    // Pack the decode instruction into a slot descriptor for the pipe.
    always_comb begin
        id_slot            = '0;
        id_slot.valid      = id_valid;
        id_slot.rd         = id_rd;
        id_slot.is_load    = id_is_load;
        id_slot.is_store   = id_is_store;
        id_slot.is_branch  = id_is_branch;
        id_slot.pred_taken = id_pred_taken;
    end

    hdu_slot_pipe u_pipe (
        .clk        (clk),
        .rst        (rst),
        .freeze_i   (pc_freeze),
        .flush_i    (do_flush),
        .id_slot_i  (id_slot),
        .ex_o       (ex_slot),
        .mem_o      (mem_slot),
        .wb_o       (wb_slot),
        .mem_enter_o(mem_enter)
    );

    // Memory-port busy timer: reload on a load/store entering MEM, else count down.
    always_comb begin
        mem_busy_d = mem_busy_q;
        if (mem_enter) begin
            mem_busy_d = BUSY_RELOAD;
        end else if (mem_busy_q != 3'd0) begin
            mem_busy_d = mem_busy_q - 3'd1;
        end
    end

    // Busy timer register; a flush does not clear an occupied port.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_busy_q <= 3'd0;
        end else begin
            mem_busy_q <= mem_busy_d;
        end
    end

    // Hazard terms from the current ID instruction and EX/MEM slots.
    always_comb begin
        rs1_ex  = src_match(id_rs1, ex_slot);
        rs1_mem = src_match(id_rs1, mem_slot);
        rs2_ex  = src_match(id_rs2, ex_slot);
        rs2_mem = src_match(id_rs2, mem_slot);

        data_d   = id_valid && (rs1_ex || rs1_mem || rs2_ex || rs2_mem);
        // A load still in EX has no result yet, so it cannot be forwarded.
        fwrd_d   = data_d && !((rs1_ex || rs2_ex) && ex_slot.is_load);
        str_d    = id_valid && (id_is_load || id_is_store) && (mem_busy_q != 3'd0);
        ctrl_d   = (id_valid && id_is_branch) ||
                   (ex_slot.valid && ex_slot.is_branch && !ex_br_resolve);
        branch_d = ex_slot.valid && ex_slot.is_branch && ex_br_resolve;
        crct_d   = branch_d && (ex_br_taken == ex_slot.pred_taken);

        sel_a_d = FWD_NONE;
        if (rs1_ex && !ex_slot.is_load) begin
            sel_a_d = FWD_EX;
        end else if (rs1_mem) begin
            sel_a_d = FWD_MEM;
        end

        sel_b_d = FWD_NONE;
        if (rs2_ex && !ex_slot.is_load) begin
            sel_b_d = FWD_EX;
        end else if (rs2_mem) begin
            sel_b_d = FWD_MEM;
        end
    end

    // Output registers: one cycle of latency to line up with the resolver.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= 1'b0;
            fwrd_q   <= 1'b0;
            str_q    <= 1'b0;
            ctrl_q   <= 1'b0;
            branch_q <= 1'b0;
            crct_q   <= 1'b0;
            sel_a_q  <= FWD_NONE;
            sel_b_q  <= FWD_NONE;
        end else begin
            data_q   <= data_d;
            fwrd_q   <= fwrd_d;
            str_q    <= str_d;
            ctrl_q   <= ctrl_d;
            branch_q <= branch_d;
            crct_q   <= crct_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
        end
    end

    assign data      = data_q;
    assign fwrd      = fwrd_q;
    assign str       = str_q;
    assign ctrl      = ctrl_q;
    assign branch    = branch_q;
    assign crct      = crct_q;
    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit: directed scenarios plus a
// randomized run against a behavioural pipeline model.
module tb_hazard_detect_unit;

    localparam int RW   = 5;
    localparam int BUSY = 2;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_is_load, id_is_store, id_is_branch, id_pred_taken;
    logic          ex_br_resolve, ex_br_taken, pc_freeze, do_flush;
    logic          data, fwrd, str, ctrl, branch, crct;
    logic [1:0]    fwd_sel_a, fwd_sel_b;

    logic [9:0] obs;
    assign obs = {data, fwrd, str, ctrl, branch, crct, fwd_sel_a, fwd_sel_b};

    int n_checks = 0;
    int n_errors = 0;

    // Model: index 0 = EX, 1 = MEM, 2 = WB.
    bit       m_v  [3];
    int       m_rd [3];
    bit       m_ld [3];
    bit       m_st [3];
    bit       m_br [3];
    bit       m_pt [3];
    int       m_busy;
    logic [9:0] exp_vec;

    hazard_detect_unit #(.REG_W(RW), .MEM_BUSY_CYC(BUSY)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_is_load   (id_is_load),
        .id_is_store  (id_is_store),
        .id_is_branch (id_is_branch),
        .id_pred_taken(id_pred_taken),
        .ex_br_resolve(ex_br_resolve),
        .ex_br_taken  (ex_br_taken),
        .pc_freeze    (pc_freeze),
        .do_flush     (do_flush),
        .data         (data),
        .fwrd         (fwrd),
        .str          (str),
        .ctrl         (ctrl),
        .branch       (branch),
        .crct         (crct),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit hits(input int src, input int k);
        return src != 0 && m_v[k] && m_rd[k] == src;
    endfunction

    function automatic logic [1:0] pick(input int src);
        if (hits(src, 0) && !m_ld[0]) return 2'b01;
        if (hits(src, 1))             return 2'b10;
        return 2'b00;
    endfunction

    // Expected registered outputs after the coming edge.
    task automatic model_eval();
        bit any_hit, ex_load_hit, e_data, e_fwrd, e_str, e_ctrl, e_br, e_crct;
        int s1, s2;
        s1 = int'(id_rs1);
        s2 = int'(id_rs2);
        any_hit     = hits(s1, 0) || hits(s1, 1) || hits(s2, 0) || hits(s2, 1);
        ex_load_hit = (hits(s1, 0) || hits(s2, 0)) && m_ld[0];
        e_data = id_valid && any_hit;
        e_fwrd = e_data && !ex_load_hit;
        e_str  = id_valid && (id_is_load || id_is_store) && m_busy > 0;
        e_ctrl = (id_valid && id_is_branch) || (m_v[0] && m_br[0] && !ex_br_resolve);
        e_br   = m_v[0] && m_br[0] && ex_br_resolve;
        e_crct = e_br && (ex_br_taken == m_pt[0]);
        if (rst) exp_vec = '0;
        else     exp_vec = {e_data, e_fwrd, e_str, e_ctrl, e_br, e_crct, pick(s1), pick(s2)};
    endtask

    // Advance the model's slots and port timer across one clock edge.
    task automatic model_advance();
        bit enters;
        if (rst) begin
            for (int k = 0; k < 3; k++) m_v[k] = 0;
            m_busy = 0;
            return;
        end
        enters = !do_flush && m_v[0] && (m_ld[0] || m_st[0]);
        for (int k = 2; k > 0; k--) begin
            m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
            m_st[k] = m_st[k-1]; m_br[k] = m_br[k-1]; m_pt[k] = m_pt[k-1];
        end
        if (do_flush) m_v[1] = 0;
        if (do_flush || pc_freeze) begin
            m_v[0] = 0;
        end else begin
            m_v[0] = id_valid; m_rd[0] = int'(id_rd); m_ld[0] = id_is_load;
            m_st[0] = id_is_store; m_br[0] = id_is_branch; m_pt[0] = id_pred_taken;
        end
        if (enters)          m_busy = BUSY - 1;
        else if (m_busy > 0) m_busy = m_busy - 1;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                          input bit ld, input bit st, input bit br, input bit pt);
        id_valid = v; id_rs1 = RW'(rs1); id_rs2 = RW'(rs2); id_rd = RW'(rd);
        id_is_load = ld; id_is_store = st; id_is_branch = br; id_pred_taken = pt;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        pc_freeze = 0; do_flush = 0; ex_br_resolve = 0; ex_br_taken = 0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        pc_freeze = 0; do_flush = 0; ex_br_resolve = 0; ex_br_taken = 0;
        tick(); tick();
        n_checks++;
        if (obs !== 10'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 10'b0);
        end
        rst = 0;
    endtask

    task automatic test_raw_fwd();
        drain();
        set_id(1, 0, 0, 3, 0, 0, 0, 0); tick();
        set_id(1, 3, 4, 6, 0, 0, 0, 0); tick();
        n_checks++;
        if (obs !== 10'b11_0000_01_00) begin
            n_errors++;
            $display("FAIL raw_fwd_ex: got %b expected %b", obs, 10'b11_0000_01_00);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_id(1, 0, 0, 5, 1, 0, 0, 0); tick();
        set_id(1, 0, 5, 8, 0, 0, 0, 0); pc_freeze = 1; tick();
        n_checks++;
        if (obs !== 10'b10_0000_00_00) begin
            n_errors++;
            $display("FAIL load_use_stall: got %b expected %b", obs, 10'b10_0000_00_00);
        end
        pc_freeze = 0; tick();
        n_checks++;
        if (obs !== 10'b11_0000_00_10) begin
            n_errors++;
            $display("FAIL load_use_mem_fwd: got %b expected %b", obs, 10'b11_0000_00_10);
        end
    endtask

    task automatic test_x0();
        drain();
        set_id(1, 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 2, 0, 0, 0, 0); tick();
        n_checks++;
        if (obs !== 10'b0) begin
            n_errors++;
            $display("FAIL x0_immunity: got %b expected %b", obs, 10'b0);
        end
    endtask

    task automatic test_struct();
        drain();
        set_id(1, 0, 0, 0, 0, 1, 0, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 9, 1, 0, 0, 0); pc_freeze = 1; tick();
        n_checks++;
        if (obs !== 10'b00_1000_00_00) begin
            n_errors++;
            $display("FAIL struct_busy: got %b expected %b", obs, 10'b00_1000_00_00);
        end
        pc_freeze = 0; tick();
        n_checks++;
        if (obs !== 10'b0) begin
            n_errors++;
            $display("FAIL struct_free: got %b expected %b", obs, 10'b0);
        end
    endtask

    task automatic test_branch();
        drain();
        set_id(1, 0, 0, 7, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 0, 0, 0, 1, 1); tick();
        n_checks++;
        if (obs !== 10'b00_0100_00_00) begin
            n_errors++;
            $display("FAIL branch_ctrl_id: got %b expected %b", obs, 10'b00_0100_00_00);
        end
        set_id(1, 0, 0, 9, 0, 0, 0, 0); ex_br_resolve = 1; ex_br_taken = 0; tick();
        n_checks++;
        if (obs !== 10'b00_0010_00_00) begin
            n_errors++;
            $display("FAIL branch_mispredict: got %b expected %b", obs, 10'b00_0010_00_00);
        end
        set_id(1, 0, 0, 10, 0, 0, 0, 0); ex_br_resolve = 0; do_flush = 1; tick();
        n_checks++;
        if (obs !== 10'b0) begin
            n_errors++;
            $display("FAIL flush_cycle: got %b expected %b", obs, 10'b0);
        end
        set_id(1, 9, 7, 11, 0, 0, 0, 0); do_flush = 0; tick();
        n_checks++;
        if (obs !== 10'b0) begin
            n_errors++;
            $display("FAIL post_flush_squash: got %b expected %b", obs, 10'b0);
        end
        drain();
        set_id(1, 0, 0, 0, 0, 0, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); ex_br_resolve = 1; ex_br_taken = 0; tick();
        n_checks++;
        if (obs !== 10'b00_0011_00_00) begin
            n_errors++;
            $display("FAIL branch_correct: got %b expected %b", obs, 10'b00_0011_00_00);
        end
        ex_br_resolve = 0;
    endtask

    task automatic test_reset_mid();
        drain();
        set_id(1, 0, 0, 1, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 2, 1, 0, 0, 0); tick();
        set_id(1, 0, 0, 3, 0, 0, 0, 0); tick();
        set_id(1, 3, 2, 4, 0, 0, 1, 0); rst = 1; tick();
        n_checks++;
        if (obs !== 10'b0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got %b expected %b", obs, 10'b0);
        end
        rst = 0; tick();
        n_checks++;
        if (obs !== 10'b00_0100_00_00) begin
            n_errors++;
            $display("FAIL reset_mid_stale: got %b expected %b", obs, 10'b00_0100_00_00);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1));
            ex_br_resolve = $urandom_range(0, 1);
            ex_br_taken   = $urandom_range(0, 1);
            pc_freeze     = ($urandom_range(0, 5) == 0);
            do_flush      = ($urandom_range(0, 7) == 0);
            tick();
            n_checks++;
            if (obs !== exp_vec) begin
                n_errors++;
                $display("FAIL random_cycle_%0d: got %b expected %b", i, obs, exp_vec);
            end
        end
        rst = 0;
    endtask

    initial begin
        m_busy = 0;
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0; m_st[k] = 0; m_br[k] = 0; m_pt[k] = 0;
        end
        rst = 1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        pc_freeze = 0; do_flush = 0; ex_br_resolve = 0; ex_br_taken = 0;
        test_reset();
        test_raw_fwd();
        test_load_use();
        test_x0();
        test_struct();
        test_branch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Detects pipeline hazards and drives the hazard-resolver FSM's condition inputs: data, fwrd, str, ctrl, branch and crct.
- Tracks the decode (ID) instruction plus in-flight EX/MEM/WB descriptors in a shadow shift register.
- Consumes the resolver's pc_freeze/do_flush to insert bubbles and squash wrong-path entries.
- Sits directly upstream of the resolver, between decode and the hazard-resolution stage.

Parameters:
- REG_W, 5, register-index width
- MEM_BUSY_CYC, 2, cycles the single memory port stays busy per load/store (1..7)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID slot holds a real instruction
- id_rs1  input  REG_W  source register 1 (0 = unused/x0)
- id_rs2  input  REG_W  source register 2 (0 = unused/x0)
- id_rd  input  REG_W  destination register (0 = none)
- id_is_load  input  1  ID instruction is a load
- id_is_store  input  1  ID instruction is a store
- id_is_branch  input  1  ID instruction is a branch
- id_pred_taken  input  1  predictor outcome for the ID branch
- ex_br_resolve  input  1  EX branch outcome valid this cycle
- ex_br_taken  input  1  actual EX branch outcome
- pc_freeze  input  1  from resolver; hold ID, bubble EX
- do_flush  input  1  from resolver; squash wrong path
- data  output  1  RAW hazard on ID sources
- fwrd  output  1  RAW hazard resolvable by forwarding
- str  output  1  structural hazard on the memory port
- ctrl  output  1  control hazard pending
- branch  output  1  branch resolved in EX
- crct  output  1  prediction was correct
- fwd_sel_a  output  2  rs1 source: 00 regfile, 01 EX, 10 MEM
- fwd_sel_b  output  2  rs2 source, same encoding

Behaviour:
- Slot contents: EX, MEM and WB slots each hold {valid, rd, is_load, is_store, is_branch, pred_taken}.
- Slot advance, evaluated every clock with priority rst > do_flush > pc_freeze > normal:
  - do_flush: EX.valid<=0 and the ID instruction is dropped; MEM<=EX with valid forced 0; WB<=MEM.
  - pc_freeze: EX<=bubble (valid=0); MEM<=EX; WB<=MEM.
  - normal: EX<=ID fields with valid=id_valid; MEM<=EX; WB<=MEM.
- Memory-busy counter mem_busy (3 bits):
  - Loaded with MEM_BUSY_CYC-1 when a valid load/store enters MEM.
  - Otherwise decrements to 0 and saturates there.
  - Reload wins over decrement.
- A source "matches" a slot when: src!=0, slot.valid, slot.rd==src.
- Hazard terms, computed combinationally and registered into the outputs (1-cycle latency, aligned to the resolver's next-state sample):
  - hz = id_valid and (rs1 or rs2 matches EX or MEM).
  - data = hz.
  - fwrd = hz and no matching source hits a load in EX (load-use cannot forward). EX takes priority over MEM when both match.
  - str = id_valid and (id_is_load|id_is_store) and mem_busy!=0.
  - ctrl = (id_valid and id_is_branch) or (EX.valid and EX.is_branch and !ex_br_resolve).
  - branch = EX.valid and EX.is_branch and ex_br_resolve.
  - crct = branch and (ex_br_taken == EX.pred_taken); crct is 0 whenever branch is 0.
  - fwd_sel_a/b: 01 if the source matches EX and EX is not a load; else 10 if it matches MEM; else 00. Registered with the same latency as the flags.
- WB is tracked only so it can be observed; it never generates a hazard (the regfile writes in the first half-cycle).
- Reset: every slot invalid, mem_busy=0, all outputs 0.
- Reset mid-operation discards all in-flight state; the first valid flags appear 1 cycle after rst deasserts.
- Simultaneous flush and freeze: flush wins.
- A flush landing while mem_busy!=0 does not clear mem_busy; the port stays busy.
- id_valid=0 forces data/fwrd/str and the ID term of ctrl low.
- Unknown or garbage fields with valid=0 are ignored.

Decomposition:
- Shared package hazard_pkg holds:
  - the slot struct
  - FWD_NONE/FWD_EX/FWD_MEM constants
  - the REG_W default
  - the resolver state encoding (NOR..STAN), used by benches
- One natural sub-module, hdu_slot_pipe: the EX/MEM/WB shift register with freeze/flush handling.
- Comparators and flag registers stay in the top module.

Test Plan:
- RAW, forwardable: EX holds add rd=3; ID reads rs1=3 -> next cycle data=1, fwrd=1, fwd_sel_a=01, fwd_sel_b=00.
- Load-use: EX holds load rd=5; ID reads rs2=5 -> data=1, fwrd=0, fwd_sel_b=00. Then assert pc_freeze 1 cycle -> EX bubble; MEM match gives fwrd=1, fwd_sel_b=10.
- x0 immunity: EX holds rd=0; ID reads rs1=0 -> data=0, fwd_sel_a=00.
- Structural, MEM_BUSY_CYC=2: a store enters MEM, then ID load on the following cycle -> str=1; two cycles later, with mem_busy=0 -> str=0.
- Branch: EX branch with pred_taken=1; ex_br_resolve=1, ex_br_taken=0 -> branch=1, crct=0. Then do_flush -> EX and MEM valid=0, and the next cycle's flags are all 0.
- Reset mid-stream: fill all slots with hazards, pulse rst 1 cycle -> all outputs 0 the next cycle, and no stale match from pre-reset slots.
